data_mem_responder: RTL

Responder side of the data-memory interface driven by the pipeline's memory stage. It accepts one load/store request at a time over a valid/ready handshake and holds the little-endian data array. It applies a configurable number of wait states, then performs the byte/half/word access with lane masking and sign/zero extension. It returns a one-cycle response with read data or an alignment error; busy_o lets the hazard unit stall the pipeline.

---
 rtl/data_mem_responder_if.sv | 32 +++
 rtl/data_mem_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Purpose : request/response bundle between the pipeline memory stage and the
//           data-memory responder.
// Signals : req_valid_i/req_ready_o handshake, req_write_i, req_size_i,
//           req_unsigned_i, req_addr_i, req_wdata_i (request payload);
//           resp_valid_o, resp_rdata_o, resp_err_o (one-cycle response);
//           busy_o (request in flight, for the hazard unit).
// Modports: master = memory stage, slave = responder.
interface data_mem_responder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_write_i;
  logic [1:0]       req_size_i;
  logic             req_unsigned_i;
  logic [WIDTH-1:0] req_addr_i;
  logic [WIDTH-1:0] req_wdata_i;
  logic             resp_valid_o;
  logic [WIDTH-1:0] resp_rdata_o;
  logic             resp_err_o;
  logic             busy_o;

  modport master (
    output req_valid_i, req_write_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, busy_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Purpose : data-memory responder. Accepts one load/store at a time, waits
//           WAIT_CYCLES extra cycles, performs a byte/half/word access on a
//           little-endian word array, and returns a one-cycle response.
// Ports   : clk  - system clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - data_mem_responder_if.slave (handshake, payload, response, busy)
module data_mem_responder #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned LANES = WIDTH / 8;
  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_ready;
  logic                  r_resp_valid;
  logic [WIDTH-1:0]      r_rdata;
  logic                  r_err;
  logic                  r_busy;

  logic [WIDTH-1:0]      r_mem [DEPTH];

  logic [IDX_W-1:0]      w_idx;
  logic                  w_misalign;
  logic                  w_access;
  logic                  w_commit;
  logic [WIDTH-1:0]      w_rword;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [WIDTH-1:0]      w_load;
  logic [LANES-1:0]      w_be;
  logic [WIDTH-1:0]      w_wlane;

  // Upper address bits are dropped, so accesses alias modulo the array size.
  assign w_idx = r_addr[ADDR_WIDTH-1:2];

  assign w_misalign = (r_size == 2'b11) ||
                      ((r_size == 2'b01) && r_addr[0]) ||
                      ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));

  // Access edge: last WAIT cycle. Erroring stores never touch the array.
  assign w_access = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_commit = w_access && r_write && !w_misalign;

  assign w_rword = r_mem[w_idx];
  assign w_byte  = w_rword[{r_addr[1:0], 3'b000} +: 8];
  assign w_half  = w_rword[{r_addr[1], 4'b0000} +: 16];

  // Load lane select plus sign/zero extension.
  always_comb begin
    w_load = w_rword;
    case (r_size)
      2'b00:   w_load = r_unsigned ? WIDTH'(w_byte) : {{(WIDTH-8){w_byte[7]}}, w_byte};
      2'b01:   w_load = r_unsigned ? WIDTH'(w_half) : {{(WIDTH-16){w_half[15]}}, w_half};
      default: w_load = w_rword;
    endcase
  end

  // Store data replicated across lanes; byte enables pick the target lanes.
  always_comb begin
    w_be    = '0;
    w_wlane = r_wdata;
    case (r_size)
      2'b00: begin
        w_be[r_addr[1:0]] = 1'b1;
        w_wlane           = {LANES{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = LANES'(2'b11) << {r_addr[1], 1'b0};
        w_wlane = {(LANES/2){r_wdata[15:0]}};
      end
      2'b10:   w_be = '1;
      default: w_be = '0;
    endcase
  end

  // Data array: not reset, lane-masked writes.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wlane[b*8 +: 8];
      end
    end
  end

  // Control FSM with registered handshake/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            r_write    <= bus.req_write_i;
            r_size     <= bus.req_size_i;
            r_unsigned <= bus.req_unsigned_i;
            r_addr     <= bus.req_addr_i[ADDR_WIDTH-1:0];
            r_wdata    <= bus.req_wdata_i;
            r_cnt      <= CNT_W'(WAIT_CYCLES);
            r_state    <= S_WAIT;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_err        <= w_misalign;
            r_rdata      <= (w_misalign || r_write) ? '0 : w_load;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = r_ready;
  assign bus.resp_valid_o = r_resp_valid;
  assign bus.resp_rdata_o = r_rdata;
  assign bus.resp_err_o   = r_err;
  assign bus.busy_o       = r_busy;

endmodule
